// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Matrix-scanning front end for the microwave keypad. It drives one row of a
// 4x3 phone-style key matrix low at a time and senses the columns. Bounce and
// multi-key ghosting are rejected. The accepted key is presented as a one-hot
// digit vector plus the active-low start/clear controls.
//
// Key matrix (rows 0..3 by columns 0..2):
//   row 0: 1 2 3
//   row 1: 4 5 6
//   row 2: 7 8 9
//   row 3: * 0 #
// Internal key code = 3*row + col (0..11). Two extra codes mark an empty frame
// (NONE) and a frame with two or more keys down (MULTI).
//
// Parameters
//   SCAN_DIV   clocks each row is driven before its columns are sampled (>= 3)
//   DEBOUNCE   identical consecutive frames needed to accept a new key (>= 1)
//
// Ports
//   clock      system clock, rising edge
//   resetn     asynchronous active-low reset
//   col_n      column sense lines, active-low, asynchronous to clock
//   row_n      row drive, active-low, exactly one row low at a time
//   keypad     one-hot digit; bit d high while digit d is the accepted key
//   startn     low while '#' is the accepted key
//   clearn     low while '*' is the accepted key
//   key_valid  one-clock pulse when a new key becomes accepted
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] keypad,
    output logic       startn,
    output logic       clearn,
    output logic       key_valid
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(DEBOUNCE);

    localparam logic [3:0] CODE_STAR  = 4'd9;
    localparam logic [3:0] CODE_ZERO  = 4'd10;
    localparam logic [3:0] CODE_HASH  = 4'd11;
    localparam logic [3:0] CODE_NONE  = 4'd12;
    localparam logic [3:0] CODE_MULTI = 4'd13;

    // Synchronizer stores the inverted (active-high) column state so that the
    // cleared value also means "no key down".
    logic [2:0]    col_meta_reg;
    logic [2:0]    col_sync_reg;

    logic [1:0]    row_reg,      row_next;
    logic [DW-1:0] dwell_reg,    dwell_next;
    logic [3:0]    row_n_reg,    row_n_next;
    logic [11:0]   snapshot_reg, snapshot_next;

    logic [3:0]    cand_reg,     cand_next;
    logic [CW-1:0] count_reg,    count_next;
    logic [3:0]    accepted_reg;

    logic [9:0]    keypad_reg;
    logic          startn_reg;
    logic          clearn_reg;
    logic          key_valid_reg;

    logic          dwell_last;
    logic          frame_end;
    logic          frame_multi;
    logic [3:0]    frame_code;
    logic          accept_now;
    logic          cand_is_key;
    logic [9:0]    digit_hit;

    // -------------------------------------------------------------------------
    // Row scan and frame snapshot
    // -------------------------------------------------------------------------
    assign dwell_last = (dwell_reg == DWELL_LAST);
    assign frame_end  = dwell_last && (row_reg == 2'd3);

    always_comb begin
        dwell_next    = dwell_last ? '0 : dwell_reg + DW'(1);
        row_next      = dwell_last ? row_reg + 2'd1 : row_reg;
        row_n_next    = ~(4'b0001 << row_next);
        snapshot_next = snapshot_reg;
        if (dwell_last) begin
            case (row_reg)
                2'd0:    snapshot_next[2:0]  = col_sync_reg;
                2'd1:    snapshot_next[5:3]  = col_sync_reg;
                2'd2:    snapshot_next[8:6]  = col_sync_reg;
                default: snapshot_next[11:9] = col_sync_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Frame classification. Classifying snapshot_next lets row 3 take part in
    // the frame-end decision in the same clock that it is captured.
    // -------------------------------------------------------------------------
    assign frame_multi = |(snapshot_next & (snapshot_next - 12'd1));

    always_comb begin
        frame_code = CODE_NONE;
        for (int i = 0; i < 12; i++) begin
            if (snapshot_next[i]) begin
                frame_code = 4'(i);
            end
        end
        if (frame_multi) begin
            frame_code = CODE_MULTI;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: a code must repeat for DEBOUNCE whole frames before it replaces
    // the accepted key. Acceptance happens on the clock after the deciding
    // frame end, which is also when the decoded outputs update.
    // -------------------------------------------------------------------------
    always_comb begin
        cand_next  = cand_reg;
        count_next = count_reg;
        if (frame_end) begin
            if (frame_code == cand_reg) begin
                if (count_reg < COUNT_MAX) begin
                    count_next = count_reg + CW'(1);
                end
            end else begin
                cand_next  = frame_code;
                count_next = CW'(1);
            end
        end
    end

    assign accept_now  = (count_reg == COUNT_MAX) && (cand_reg != accepted_reg);
    assign cand_is_key = (cand_reg < CODE_NONE);

    // Digit d lives at code d-1 for 1..9 and at the middle of row 3 for 0.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_digit
            localparam logic [3:0] DIGIT_CODE = (gi == 0) ? CODE_ZERO : 4'(gi - 1);
            assign digit_hit[gi] = (cand_reg == DIGIT_CODE);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_meta_reg  <= '0;
            col_sync_reg  <= '0;
            row_reg       <= '0;
            dwell_reg     <= '0;
            row_n_reg     <= 4'b1110;
            snapshot_reg  <= '0;
            cand_reg      <= CODE_NONE;
            count_reg     <= '0;
            accepted_reg  <= CODE_NONE;
            keypad_reg    <= '0;
            startn_reg    <= 1'b1;
            clearn_reg    <= 1'b1;
            key_valid_reg <= 1'b0;
        end else begin
            col_meta_reg  <= ~col_n;
            col_sync_reg  <= col_meta_reg;
            row_reg       <= row_next;
            dwell_reg     <= dwell_next;
            row_n_reg     <= row_n_next;
            snapshot_reg  <= snapshot_next;
            cand_reg      <= cand_next;
            count_reg     <= count_next;
            if (accept_now) begin
                accepted_reg  <= cand_reg;
                keypad_reg    <= digit_hit;
                startn_reg    <= (cand_reg != CODE_HASH);
                clearn_reg    <= (cand_reg != CODE_STAR);
                key_valid_reg <= cand_is_key;
            end else begin
                key_valid_reg <= 1'b0;
            end
        end
    end

    assign row_n     = row_n_reg;
    assign keypad    = keypad_reg;
    assign startn    = startn_reg;
    assign clearn    = clearn_reg;
    assign key_valid = key_valid_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with the default parameters. A small
// matrix model turns the set of pressed keys and the driven row into col_n.
// Each stimulus step that should change the outputs pushes the expected output
// value and the clock it must appear on into a scoreboard queue; a monitor pops
// and compares whenever the outputs change or key_valid is high.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int LAT      = DEBOUNCE * FRAME + 1;

    // key indices (3*row + col)
    localparam int K1 = 0, K2 = 1, K3 = 2, K4 = 3, K5 = 4, K7 = 6, K9 = 8;
    localparam int KSTAR = 9, KHASH = 11;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       startn;
    logic       clearn;
    logic       key_valid;

    logic [11:0] pressed = '0;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct {
        logic [9:0] kp;
        logic       s;
        logic       c;
        logic       v;
        int         at;
    } exp_t;

    exp_t sb[$];

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .col_n     (col_n),
        .row_n     (row_n),
        .keypad    (keypad),
        .startn    (startn),
        .clearn    (clearn),
        .key_valid (key_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Matrix model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (row_n[r] == 1'b0) begin
                for (int c = 0; c < 3; c++) begin
                    if (pressed[3*r+c]) col_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] digit(input int d);
        logic [9:0] v;
        v = '0;
        v[d] = 1'b1;
        return v;
    endfunction

    function automatic logic [11:0] key(input int k);
        logic [11:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic push(input logic [9:0] kp, input logic s, input logic c,
                        input logic v, input int at);
        exp_t e;
        e.kp = kp; e.s = s; e.c = c; e.v = v; e.at = at;
        sb.push_back(e);
    endtask

    // Returns #1 after the clock edge on which row 0 becomes driven again.
    task automatic frame_start(output int c);
        int n;
        n = 0;
        while (row_n !== 4'b0111 && n < 4 * FRAME) begin
            @(posedge clock); #1; n++;
        end
        while (row_n !== 4'b1110 && n < 4 * FRAME) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 4 * FRAME) check("frame_align_timeout", 32'(n), 32'(0));
        c = cyc;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3 * LAT) begin
            @(posedge clock); #1; n++;
        end
        check(tag, 32'(sb.size()), 32'(0));
        sb.delete();
    endtask

    // Monitor: any output change or key_valid pulse must match the scoreboard.
    logic [11:0] prev_out = {10'd0, 1'b1, 1'b1};
    always @(negedge clock) begin
        logic [11:0] cur;
        exp_t e;
        cur = {keypad, startn, clearn};
        if (resetn && (cur !== prev_out || key_valid !== 1'b0)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {19'd0, cur, key_valid}, {19'd0, prev_out, 1'b0});
            end else begin
                e = sb.pop_front();
                check("keypad",    32'(keypad),    32'(e.kp));
                check("startn",    32'(startn),    32'(e.s));
                check("clearn",    32'(clearn),    32'(e.c));
                check("key_valid", 32'(key_valid), 32'(e.v));
                check("latency",   32'(cyc),       32'(e.at));
                $display("[TB] cycle %0d event keypad=%b startn=%b clearn=%b key_valid=%b",
                         cyc, keypad, startn, clearn, key_valid);
            end
        end
        prev_out = cur;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // ---- reset state ----------------------------------------------------
        repeat (3) @(posedge clock);
        #1;
        check("rst_row_n",     32'(row_n),     32'(4'b1110));
        check("rst_keypad",    32'(keypad),    32'(0));
        check("rst_startn",    32'(startn),    32'(1));
        check("rst_clearn",    32'(clearn),    32'(1));
        check("rst_key_valid", 32'(key_valid), 32'(0));

        resetn = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("scan_row1", 32'(row_n), 32'(4'b1101));

        // ---- asynchronous reset mid-scan ------------------------------------
        #2 resetn = 1'b0;
        #1;
        check("async_rst_row_n",  32'(row_n),  32'(4'b1110));
        check("async_rst_keypad", 32'(keypad), 32'(0));
        @(posedge clock); #1;
        resetn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); #1;
            check("rst_dwell_row", 32'(row_n), (k < 4) ? 32'(4'b1110) : 32'(4'b1101));
        end

        // ---- digit 5 press and release --------------------------------------
        frame_start(c);
        pressed = key(K5);
        push(digit(5), 1'b1, 1'b1, 1'b1, c + LAT);
        drain("digit5_press");
        frame_start(c);
        pressed = '0;
        push('0, 1'b1, 1'b1, 1'b0, c + LAT);
        drain("digit5_release");

        // ---- bounce on key 3: no event expected -----------------------------
        for (int f = 0; f < 20; f++) begin
            frame_start(c);
            pressed = (f % 2 == 0) ? key(K3) : '0;
        end
        repeat (4 * FRAME) @(posedge clock);
        #1;
        check("bounce_keypad", 32'(keypad), 32'(0));

        // ---- '#' then '*' directly ------------------------------------------
        frame_start(c);
        pressed = key(KHASH);
        push('0, 1'b0, 1'b1, 1'b1, c + LAT);
        drain("hash_press");
        frame_start(c);
        pressed = key(KSTAR);
        push('0, 1'b1, 1'b0, 1'b1, c + LAT);
        drain("star_press");
        frame_start(c);
        pressed = '0;
        push('0, 1'b1, 1'b1, 1'b0, c + LAT);
        drain("star_release");

        // ---- ghosting: 1 and 9 together, then only 9 -------------------------
        frame_start(c);
        pressed = key(K1) | key(K9);
        repeat (5 * FRAME) @(posedge clock);
        #1;
        check("multi_keypad", 32'(keypad), 32'(0));
        check("multi_startn", 32'(startn), 32'(1));
        check("multi_clearn", 32'(clearn), 32'(1));
        frame_start(c);
        pressed = key(K9);
        push(digit(9), 1'b1, 1'b1, 1'b1, c + LAT);
        drain("nine_after_multi");
        frame_start(c);
        pressed = '0;
        push('0, 1'b1, 1'b1, 1'b0, c + LAT);
        drain("nine_release");

        // ---- direct change 2 -> 4 -------------------------------------------
        frame_start(c);
        pressed = key(K2);
        push(digit(2), 1'b1, 1'b1, 1'b1, c + LAT);
        drain("two_press");
        frame_start(c);
        pressed = key(K4);
        push(digit(4), 1'b1, 1'b1, 1'b1, c + LAT);
        drain("two_to_four");
        frame_start(c);
        pressed = '0;
        push('0, 1'b1, 1'b1, 1'b0, c + LAT);
        drain("four_release");

        // ---- reset while a key is accepted -----------------------------------
        frame_start(c);
        pressed = key(K7);
        push(digit(7), 1'b1, 1'b1, 1'b1, c + LAT);
        drain("seven_press");
        repeat (5) @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        check("held_rst_keypad",    32'(keypad),    32'(0));
        check("held_rst_key_valid", 32'(key_valid), 32'(0));
        check("held_rst_row_n",     32'(row_n),     32'(4'b1110));
        pressed = '0;
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (4 * FRAME) @(posedge clock);
        #1;
        check("post_rst_keypad", 32'(keypad), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-scanning front end for the microwave keypad. It drives the rows of a 4x3 phone-style key matrix and senses its columns. It rejects bounce and multi-key ghosting, then presents the 10-bit one-hot `keypad` digit vector plus the active-low `startn`/`clearn` controls that the `microwave` block consumes. It is the transmitter side of the keypad interface and sits between the physical matrix pins and `microwave`.

## Interface
- `SCAN_DIV`, default 4: clocks each row is driven before its columns are sampled. Legal range is 3 or more, which covers the 2-flop synchronizer latency.
- `DEBOUNCE`, default 3: number of consecutive identical full-scan frames required before a new key state is accepted. Legal range is 1 or more.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `col_n`  in  3  column sense lines, active-low, pulled up, asynchronous to `clock`. Bit 0 is the leftmost column.
- `row_n`  out  4  row drive, active-low, exactly one row low at a time. Bit 0 is the top row.
- `keypad`  out  10  one-hot digit; bit i high while digit i is the accepted key, otherwise 0.
- `startn`  out  1  low while `#` is the accepted key.
- `clearn`  out  1  low while `*` is the accepted key.
- `key_valid`  out  1  one-clock pulse when a new key (digit, `*` or `#`) becomes accepted.

## Operation
- Matrix map, rows 0..3 by columns 0..2:
  - row 0: 1 2 3
  - row 1: 4 5 6
  - row 2: 7 8 9
  - row 3: * 0 #
- `col_n` passes through a 2-flop synchronizer before any use.
- Scan:
  - Row index r is 0..3 and wraps 3 to 0. A dwell counter 0..SCAN_DIV-1 advances r when it wraps.
  - `row_n` = ~(1<<r).
  - On the last dwell clock of row r, the inverted synchronized columns are written into bits [3r+2:3r] of a 12-bit frame snapshot.
- A frame ends at the last dwell clock of row 3. The snapshot is then classified:
  - No bits set: NONE.
  - Exactly one bit set: that key's code, 0..11.
  - Two or more bits set: MULTI.
- Debounce runs once per frame end:
  - If code == candidate, the count increments, saturating at DEBOUNCE.
  - Otherwise candidate <= code and count <= 1.
  - When the count reaches DEBOUNCE and candidate != accepted, accepted <= candidate.
- Outputs decode from accepted:
  - Digit d: `keypad[d]` = 1.
  - `*`: `clearn` = 0.
  - `#`: `startn` = 0.
  - NONE or MULTI: every output is inactive (`keypad` = 0, `startn` = `clearn` = 1).
  - At most one of {any `keypad` bit, `startn` low, `clearn` low} is active at a time.
- `key_valid` pulses for one clock when accepted changes to a key code. This includes a direct key-to-key change with no NONE frame in between. It does not pulse on a change to NONE or MULTI, and a key that stays held does not repeat the pulse.
- Bouncing input, meaning a code that differs between frames, keeps resetting the count, so accepted holds its previous value.

## Timing
- Reset (asynchronous, active-low resetn):
  - `row_n` = 4'b1110, `keypad` = 0, `startn` = 1, `clearn` = 1, `key_valid` = 0.
  - r, dwell, count = 0; candidate = accepted = NONE; synchronizer and snapshot cleared.
  - Asserting reset mid-frame discards the partial snapshot. Scanning restarts at row 0 on the first clock after release.
- Frame length is 4*SCAN_DIV clocks. With the defaults this is 16 clocks.
- Outputs are registered. They change on the clock after the frame end that completes the DEBOUNCE-th consecutive match.
- Press latency for a key that is stable from a frame start is DEBOUNCE*4*SCAN_DIV + 1 clocks. With the defaults this is 49 clocks. For a press at an arbitrary instant, the worst case is (DEBOUNCE+1)*4*SCAN_DIV + 3 clocks.
- Release latency is the same, using the NONE code.
- `key_valid` is asserted in the same clock that the new `keypad`/`startn`/`clearn` value first appears.

## Test plan
- Reset: hold `resetn` = 0 mid-scan → `row_n` = 1110 immediately, `keypad` = 0, `startn` = `clearn` = 1, `key_valid` = 0. After release, row 0 dwells 4 clocks, then `row_n` = 1101.
- Digit 5 (row 1, col 1) held from a frame start → 49 clocks later `keypad` = 10'b0000100000 with a single `key_valid` pulse. On release, `keypad` returns to 0 after 3 frames, with no pulse.
- Bounce: key 3 pressed on alternate frames for 20 frames → `keypad` stays 0 and `key_valid` never pulses.
- `#` held → `startn` = 0 and `keypad` = 0, with one pulse. Then `*` held → `clearn` = 0 and `startn` = 1.
- Keys 1 and 9 held together → all outputs inactive. Release 1 and keep 9 → `keypad` = 10'b1000000000 after 3 frames, with one pulse.
- Direct change from 2 to 4 with no release frame → `keypad` goes from bit 2 to bit 4 after 3 frames, with one pulse at the change.
